// File: rtl/compute_tile_wb_req_bridge.sv
// compute_tile_wb_req_bridge
// Registered Wishbone classic bridge from the network adapter master to the tile
// slave subsystem. It adds one register stage in each direction, rejects accesses
// outside an address window and turns a hung access into a bus error once a
// programmable timeout expires.
// Optional: define COMPUTE_TILE_WB_BRIDGE_STATS_EN to add saturating counters for
// completed acks, timeouts and out-of-window rejects.
module compute_tile_wb_req_bridge #(
    parameter logic [31:0] ADDR_MASK      = 32'h0000_0000,
    parameter logic [31:0] ADDR_MATCH     = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1024,
    localparam int         TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    // upstream, from the NA master
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o,
    // downstream, to orpsoc_top
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i
`ifdef COMPUTE_TILE_WB_BRIDGE_STATS_EN
    ,
    output logic [31:0] stat_txn_o,
    output logic [31:0] stat_tmo_o,
    output logic [31:0] stat_win_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    state_t        state;
    logic [TW-1:0] cnt;
    logic          req;
    logic          in_win;
    logic          tmo_hit;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign in_win  = (wbs_adr_i & ADDR_MASK) == ADDR_MATCH;
    // slave response always takes precedence over an expiring timer
    assign tmo_hit = (cnt == TMO_LIMIT) & ~wbm_ack_i & ~wbm_err_i;

    // Bridge FSM: every bus output is a register driven from here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (in_win) begin
                            wbm_adr_o <= wbs_adr_i;
                            wbm_dat_o <= wbs_dat_i;
                            wbm_sel_o <= wbs_sel_i;
                            wbm_we_o  <= wbs_we_i;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            cnt       <= '0;
                            state     <= FWD;
                        end else begin
                            wbs_err_o <= 1'b1;
                            wbs_dat_o <= '0;
                            state     <= RESP;
                        end
                    end
                end
                FWD: begin
                    if (!wbs_cyc_i) begin
                        // master gave up: release the slave, nobody to answer
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= IDLE;
                    end else if (wbm_err_i || wbm_ack_i || tmo_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= RESP;
                        if (wbm_ack_i && !wbm_err_i) begin
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= wbm_dat_i;
                        end else begin
                            wbs_err_o <= 1'b1;
                            wbs_dat_o <= '0;
                        end
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef COMPUTE_TILE_WB_BRIDGE_STATS_EN
    logic resp_tmo;
    logic resp_win;

    // Remember why the pending response is an error so RESP can classify it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_tmo <= 1'b0;
            resp_win <= 1'b0;
        end else begin
            resp_tmo <= (state == FWD) & wbs_cyc_i & tmo_hit;
            resp_win <= (state == IDLE) & req & ~in_win;
        end
    end

    // Saturating event counters, bumped in the response cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_txn_o <= '0;
            stat_tmo_o <= '0;
            stat_win_o <= '0;
        end else if (state == RESP) begin
            if (wbs_ack_o && stat_txn_o != 32'hFFFF_FFFF) stat_txn_o <= stat_txn_o + 1'b1;
            if (resp_tmo && stat_tmo_o != 32'hFFFF_FFFF) stat_tmo_o <= stat_tmo_o + 1'b1;
            if (resp_win && stat_win_o != 32'hFFFF_FFFF) stat_win_o <= stat_win_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_compute_tile_wb_req_bridge.sv
// Bench for compute_tile_wb_req_bridge: a scoreboard holds the expected upstream
// response of each request and is popped when wbs_ack_o/wbs_err_o appears.
module tb_compute_tile_wb_req_bridge;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic [3:0]  wbs_sel_i = '0;
    logic        wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
    logic        wbs_ack_o, wbs_err_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;
`ifdef COMPUTE_TILE_WB_BRIDGE_STATS_EN
    logic [31:0] stat_txn_o, stat_tmo_o, stat_win_o;
`endif

    compute_tile_wb_req_bridge #(
        .ADDR_MASK(32'hF000_0000), .ADDR_MATCH(32'h0000_0000), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i)
`ifdef COMPUTE_TILE_WB_BRIDGE_STATS_EN
        , .stat_txn_o(stat_txn_o), .stat_tmo_o(stat_tmo_o), .stat_win_o(stat_win_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t sbq[$];
    int   vectors = 0;
    int   errors  = 0;
    bit   expect_rsp = 1'b0;
    int   exp_txn = 0, exp_tmo = 0, exp_win = 0;

    // slave behaviour: 0 ack, 1 err, 2 silent, 3 ack+err; fires on strobe cycle sl_delay
    int          sl_mode = 2, sl_delay = 1;
    logic [31:0] sl_data = '0;
    int          scnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (wbm_cyc_o && wbm_stb_o) scnt++;
            else scnt = 0;
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            wbm_dat_i = '0;
            if (scnt != 0 && scnt == sl_delay) begin
                if (sl_mode == 0 || sl_mode == 3) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = sl_data;
                end
                if (sl_mode == 1 || sl_mode == 3) wbm_err_i = 1'b1;
            end
        end
    end

    // unsolicited or double responses
    initial begin
        forever begin
            @(negedge clk);
            if (wbs_ack_o && wbs_err_o) begin
                errors++;
                $display("FAIL both_ack_err: ack=1 err=1 required only one");
            end
            if ((wbs_ack_o || wbs_err_o) && !expect_rsp) begin
                errors++;
                $display("FAIL spurious_rsp: ack=%0b err=%0b required none", wbs_ack_o, wbs_err_o);
            end
        end
    end

    // kind: 0 ack, 1 slave err, 2 timeout, 3 out-of-window
    task automatic run_txn(input string name, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit we, input int mode, input int delay,
                           input logic [31:0] sdat, input int kind, input logic [31:0] exp_dat,
                           input int exp_lat, input int exp_fwd);
        rsp_t r, got;
        int   n, fwd;
        bit   done, field_bad;
        sl_mode = mode; sl_delay = delay; sl_data = sdat;
        r.is_err = (kind != 0);
        r.dat    = exp_dat;
        sbq.push_back(r);
        expect_rsp = 1'b1;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        n = 0; fwd = 0; done = 0; field_bad = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (wbm_cyc_o) begin
                fwd++;
                if (wbm_adr_o !== adr || wbm_dat_o !== dat || wbm_sel_o !== sel ||
                    wbm_we_o !== we || wbm_stb_o !== 1'b1) field_bad = 1;
            end
            if (wbs_ack_o || wbs_err_o) done = 1;
        end
        vectors++;
        got = sbq.pop_front();
        if (!done) begin
            errors++;
            $display("FAIL %s_no_rsp: no ack/err in %0d cycles, required one", name, n);
        end else begin
            if (wbs_err_o !== got.is_err || wbs_ack_o !== !got.is_err) begin
                errors++;
                $display("FAIL %s_kind: ack=%0b err=%0b required err=%0b", name, wbs_ack_o, wbs_err_o, got.is_err);
            end
            if (wbs_dat_o !== got.dat) begin
                errors++;
                $display("FAIL %s_dat: got %h required %h", name, wbs_dat_o, got.dat);
            end
            if (n != exp_lat) begin
                errors++;
                $display("FAIL %s_latency: got %0d required %0d", name, n, exp_lat);
            end
        end
        if (fwd != exp_fwd || field_bad) begin
            errors++;
            $display("FAIL %s_fwd: wbm_cyc cycles %0d required %0d, field_bad=%0b", name, fwd, exp_fwd, field_bad);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (wbs_ack_o || wbs_err_o || wbm_cyc_o) begin
            errors++;
            $display("FAIL %s_after: ack=%0b err=%0b wbm_cyc=%0b required 0", name, wbs_ack_o, wbs_err_o, wbm_cyc_o);
        end
        expect_rsp = 1'b0;
        if (kind == 0) exp_txn++;
        if (kind == 2) exp_tmo++;
        if (kind == 3) exp_win++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({wbs_ack_o, wbs_err_o, wbs_dat_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
             wbm_cyc_o, wbm_stb_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: nonzero output after reset, required all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        run_txn("read", 32'h0000_0100, 32'h0, 4'hF, 1'b0, 0, 2, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 3, 2);
        run_txn("read_fast", 32'h0000_0200, 32'h0, 4'hF, 1'b0, 0, 1, 32'h0BAD_BEEF, 0, 32'h0BAD_BEEF, 2, 1);
    endtask

    task automatic test_write();
        run_txn("write", 32'h0000_0010, 32'h1234_5678, 4'b0011, 1'b1, 0, 4, 32'h5555_AAAA, 0, 32'h5555_AAAA, 5, 4);
    endtask

    task automatic test_window();
        // previous read left nonzero read data; an error must clear it
        run_txn("window", 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 0, 1, 32'h1, 3, 32'h0, 1, 0);
        run_txn("window_edge", 32'h1000_0000, 32'h0, 4'hF, 1'b0, 0, 1, 32'h1, 3, 32'h0, 1, 0);
    endtask

    task automatic test_timeout();
        run_txn("pre_tmo", 32'h0000_0400, 32'h0, 4'hF, 1'b0, 0, 3, 32'hDEAD_0001, 0, 32'hDEAD_0001, 4, 3);
        run_txn("timeout", 32'h0FFF_FFFC, 32'h0, 4'hF, 1'b0, 2, 1, 32'h0, 2, 32'h0, T + 2, T + 1);
    endtask

    task automatic test_priority();
        run_txn("slv_err", 32'h0000_0020, 32'h0, 4'hF, 1'b0, 1, 2, 32'h0, 1, 32'h0, 3, 2);
        run_txn("ack_err_both", 32'h0000_0024, 32'h0, 4'hF, 1'b0, 3, 2, 32'h7777_7777, 1, 32'h0, 3, 2);
        run_txn("ack_at_tmo", 32'h0000_0028, 32'h0, 4'hF, 1'b0, 0, T + 1, 32'h600D_CAFE, 0, 32'h600D_CAFE, T + 2, T + 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            int          d;
            logic [31:0] a, v;
            d = $urandom_range(1, 4);
            a = {4'h0, 28'($urandom) & 28'hFFF_FFFC};
            v = $urandom;
            run_txn("b2b", a, v, 4'($urandom), 1'($urandom), 0, d, ~v, 0, ~v, d + 1, d);
        end
    endtask

    task automatic test_stats();
`ifdef COMPUTE_TILE_WB_BRIDGE_STATS_EN
        vectors++;
        if (stat_txn_o !== 32'(exp_txn) || stat_tmo_o !== 32'(exp_tmo) || stat_win_o !== 32'(exp_win)) begin
            errors++;
            $display("FAIL stats: txn=%0d tmo=%0d win=%0d required %0d %0d %0d",
                     stat_txn_o, stat_tmo_o, stat_win_o, exp_txn, exp_tmo, exp_win);
        end
`endif
    endtask

    task automatic test_abort();
        bit seen;
        sl_mode = 2;
        wbs_adr_i = 32'h0000_0300; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (wbm_cyc_o || wbm_stb_o) begin
            errors++;
            $display("FAIL abort_drop: wbm_cyc=%0b wbm_stb=%0b required 0", wbm_cyc_o, wbm_stb_o);
        end
        seen = 0;
        repeat (T + 4) begin
            @(negedge clk);
            if (wbs_ack_o || wbs_err_o || wbm_cyc_o) seen = 1;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: activity after abort, required none");
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        sl_mode = 2;
        wbs_adr_i = 32'h0000_0304;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (!wbm_cyc_o) begin
            errors++;
            $display("FAIL rstmid_fwd: wbm_cyc=%0b required 1", wbm_cyc_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (wbm_cyc_o || wbm_stb_o || wbs_ack_o || wbs_err_o) begin
            errors++;
            $display("FAIL rstmid_drop: wbm_cyc=%0b ack=%0b err=%0b required 0", wbm_cyc_o, wbs_ack_o, wbs_err_o);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        repeat (T + 4) begin
            @(negedge clk);
            if (wbs_ack_o || wbs_err_o || wbm_cyc_o) seen = 1;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL rstmid_quiet: activity after reset, required none");
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_window();
        test_timeout();
        test_priority();
        test_back_to_back();
        test_stats();
        test_abort();
        test_reset_mid();
        vectors++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d entries required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
